// File: rtl/decode_ctrl_pipe.sv
// Decode stage control generation plus the D->E control pipeline register.
// Multicycle RV32M ops hold E through a down-counter that drives BusyE.
module decode_ctrl_pipe #(
    parameter int MEXT    = 1,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcD,
    input  logic [2:0] f3D,
    input  logic [6:0] f7D,
    input  logic       flushE,
    input  logic       stallE,
    output logic [2:0] ImmSrcD,
    output logic       RegWriteE,
    output logic       MemWriteE,
    output logic       ALUSrcE,
    output logic       JalrE,
    output logic       JumpE,
    output logic       BranchE,
    output logic [1:0] ResultSrcE,
    output logic [3:0] ALUControlE,
    output logic [2:0] BrTypeE,
    output logic       IllegalE,
    output logic       BusyE
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_MUL  = 4'b1010;
    localparam logic [3:0] ALU_MULH = 4'b1011;
    localparam logic [3:0] ALU_DIV  = 4'b1100;
    localparam logic [3:0] ALU_DIVU = 4'b1101;
    localparam logic [3:0] ALU_REM  = 4'b1110;
    localparam logic [3:0] ALU_REMU = 4'b1111;

    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    logic       reg_write, mem_write, alu_src, jalr, jump, branch, illegal;
    logic       is_mul, is_div;
    logic [1:0] result_src;
    logic [3:0] alu_control;
    logic [2:0] br_type, imm_src;
    logic [3:0] cnt;

    assign BusyE   = (cnt != 4'd0);
    assign ImmSrcD = imm_src;

    // Decode the D-stage instruction; illegal encodings collapse to all-zero controls.
    always_comb begin
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        alu_src     = 1'b0;
        jalr        = 1'b0;
        jump        = 1'b0;
        branch      = 1'b0;
        illegal     = 1'b0;
        is_mul      = 1'b0;
        is_div      = 1'b0;
        result_src  = 2'b00;
        alu_control = ALU_ADD;
        br_type     = 3'b000;
        imm_src     = 3'b000;
        case (opcD)
            7'd3: begin
                if (f3D == 3'd2) begin
                    reg_write  = 1'b1;
                    alu_src    = 1'b1;
                    result_src = 2'b01;
                end else illegal = 1'b1;
            end
            7'd35: begin
                if (f3D == 3'd2) begin
                    mem_write = 1'b1;
                    alu_src   = 1'b1;
                    imm_src   = 3'b001;
                end else illegal = 1'b1;
            end
            7'd99: begin
                if (f3D != 3'd2 && f3D != 3'd3) begin
                    branch      = 1'b1;
                    imm_src     = 3'b010;
                    alu_control = ALU_SUB;
                    br_type     = f3D;
                end else illegal = 1'b1;
            end
            7'd51: begin
                reg_write = 1'b1;
                if (f7D == 7'd0) begin
                    case (f3D)
                        3'd0:    alu_control = ALU_ADD;
                        3'd1:    alu_control = ALU_SLL;
                        3'd2:    alu_control = ALU_SLT;
                        3'd3:    alu_control = ALU_SLTU;
                        3'd4:    alu_control = ALU_XOR;
                        3'd5:    alu_control = ALU_SRL;
                        3'd6:    alu_control = ALU_OR;
                        default: alu_control = ALU_AND;
                    endcase
                end else if (f7D == 7'd32 && f3D == 3'd0) begin
                    alu_control = ALU_SUB;
                end else if (f7D == 7'd32 && f3D == 3'd5) begin
                    alu_control = ALU_SRA;
                end else if (f7D == 7'd1 && MEXT != 0) begin
                    case (f3D)
                        3'd0: begin alu_control = ALU_MUL;  is_mul = 1'b1; end
                        3'd1: begin alu_control = ALU_MULH; is_mul = 1'b1; end
                        3'd4: begin alu_control = ALU_DIV;  is_div = 1'b1; end
                        3'd5: begin alu_control = ALU_DIVU; is_div = 1'b1; end
                        3'd6: begin alu_control = ALU_REM;  is_div = 1'b1; end
                        3'd7: begin alu_control = ALU_REMU; is_div = 1'b1; end
                        default: illegal = 1'b1;
                    endcase
                end else illegal = 1'b1;
            end
            7'd19: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                case (f3D)
                    3'd0: alu_control = ALU_ADD;
                    3'd2: alu_control = ALU_SLT;
                    3'd3: alu_control = ALU_SLTU;
                    3'd4: alu_control = ALU_XOR;
                    3'd6: alu_control = ALU_OR;
                    3'd7: alu_control = ALU_AND;
                    3'd1: begin
                        if (f7D == 7'd0) alu_control = ALU_SLL;
                        else illegal = 1'b1;
                    end
                    default: begin
                        if (f7D == 7'd0) alu_control = ALU_SRL;
                        else if (f7D == 7'd32) alu_control = ALU_SRA;
                        else illegal = 1'b1;
                    end
                endcase
            end
            7'd111: begin
                reg_write  = 1'b1;
                imm_src    = 3'b011;
                jump       = 1'b1;
                result_src = 2'b10;
            end
            7'd55: begin
                reg_write  = 1'b1;
                imm_src    = 3'b100;
                result_src = 2'b11;
            end
            7'd103: begin
                if (f3D == 3'd0) begin
                    reg_write  = 1'b1;
                    alu_src    = 1'b1;
                    jalr       = 1'b1;
                    result_src = 2'b10;
                end else illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            reg_write   = 1'b0;
            mem_write   = 1'b0;
            alu_src     = 1'b0;
            jalr        = 1'b0;
            jump        = 1'b0;
            branch      = 1'b0;
            is_mul      = 1'b0;
            is_div      = 1'b0;
            result_src  = 2'b00;
            alu_control = ALU_ADD;
            br_type     = 3'b000;
            imm_src     = 3'b000;
        end
    end

    // E-stage control register: reset, then flush to bubble, then hold, then load.
    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            ALUSrcE     <= 1'b0;
            JalrE       <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ResultSrcE  <= 2'b00;
            ALUControlE <= 4'b0000;
            BrTypeE     <= 3'b000;
            IllegalE    <= 1'b0;
        end else if (!(stallE || BusyE)) begin
            RegWriteE   <= reg_write;
            MemWriteE   <= mem_write;
            ALUSrcE     <= alu_src;
            JalrE       <= jalr;
            JumpE       <= jump;
            BranchE     <= branch;
            ResultSrcE  <= result_src;
            ALUControlE <= alu_control;
            BrTypeE     <= br_type;
            IllegalE    <= illegal;
        end
    end

    // Remaining-occupancy counter: armed on load of a multicycle op, frozen by stallE.
    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            cnt <= 4'd0;
        end else if (BusyE) begin
            if (!stallE) cnt <= cnt - 4'd1;
        end else if (!stallE) begin
            if (is_mul)      cnt <= MUL_CNT;
            else if (is_div) cnt <= DIV_CNT;
            else             cnt <= 4'd0;
        end
    end

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: three instances (M-ext with 3/8 latency, no M-ext,
// M-ext with 1/2 latency) share one stimulus stream and are scored against a model.
module tb_decode_ctrl_pipe;

    localparam int P_MEXT[3] = '{1, 0, 1};
    localparam int P_MUL[3]  = '{3, 3, 1};
    localparam int P_DIV[3]  = '{8, 8, 2};
    // ALU code per funct3 for the base integer ops (shared by R-type f7=0 and I-ALU)
    localparam int R_ALU[8]  = '{0, 7, 5, 6, 4, 8, 3, 2};
    // ALU code per funct3 for RV32M; -1 marks an illegal funct3
    localparam int M_ALU[8]  = '{10, 11, -1, -1, 12, 13, 14, 15};
    localparam int OPS[9]    = '{3, 35, 99, 51, 19, 111, 55, 103, 23};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush_e, stall_e;
    logic [6:0] opc, f7;
    logic [2:0] f3;

    logic [2:0] imm_src[3];
    logic       rw[3], mw[3], as[3], jr[3], jp[3], br[3], il[3], bz[3];
    logic [1:0] rs[3];
    logic [3:0] alu[3];
    logic [2:0] bt[3];
    logic [16:0] act_v[3];

    int checks = 0;
    int errors = 0;

    logic [16:0] exp_q[3][$];
    logic [15:0] m_e[3];
    int          m_left[3];

    decode_ctrl_pipe #(.MEXT(1), .MUL_LAT(3), .DIV_LAT(8)) dut0 (
        .clk(clk), .rst(rst), .opcD(opc), .f3D(f3), .f7D(f7), .flushE(flush_e), .stallE(stall_e),
        .ImmSrcD(imm_src[0]), .RegWriteE(rw[0]), .MemWriteE(mw[0]), .ALUSrcE(as[0]), .JalrE(jr[0]),
        .JumpE(jp[0]), .BranchE(br[0]), .ResultSrcE(rs[0]), .ALUControlE(alu[0]), .BrTypeE(bt[0]),
        .IllegalE(il[0]), .BusyE(bz[0]));

    decode_ctrl_pipe #(.MEXT(0), .MUL_LAT(3), .DIV_LAT(8)) dut1 (
        .clk(clk), .rst(rst), .opcD(opc), .f3D(f3), .f7D(f7), .flushE(flush_e), .stallE(stall_e),
        .ImmSrcD(imm_src[1]), .RegWriteE(rw[1]), .MemWriteE(mw[1]), .ALUSrcE(as[1]), .JalrE(jr[1]),
        .JumpE(jp[1]), .BranchE(br[1]), .ResultSrcE(rs[1]), .ALUControlE(alu[1]), .BrTypeE(bt[1]),
        .IllegalE(il[1]), .BusyE(bz[1]));

    decode_ctrl_pipe #(.MEXT(1), .MUL_LAT(1), .DIV_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .opcD(opc), .f3D(f3), .f7D(f7), .flushE(flush_e), .stallE(stall_e),
        .ImmSrcD(imm_src[2]), .RegWriteE(rw[2]), .MemWriteE(mw[2]), .ALUSrcE(as[2]), .JalrE(jr[2]),
        .JumpE(jp[2]), .BranchE(br[2]), .ResultSrcE(rs[2]), .ALUControlE(alu[2]), .BrTypeE(bt[2]),
        .IllegalE(il[2]), .BusyE(bz[2]));

    for (genvar g = 0; g < 3; g++) begin : g_act
        assign act_v[g] = {rw[g], mw[g], as[g], jr[g], jp[g], br[g], rs[g], alu[g], bt[g], il[g], bz[g]};
    end

    // Reference decode: instruction name -> controls. cls 0 single-cycle, 1 mul, 2 div.
    function automatic void ref_dec(input logic [6:0] o, input logic [2:0] f, input logic [6:0] s,
                                    input int mext, output logic [15:0] ctl,
                                    output logic [2:0] imm, output int cls);
        logic       w, m, a, j_r, j_p, b, ill;
        logic [1:0] r;
        logic [3:0] op;
        logic [2:0] t;
        w = 0; m = 0; a = 0; j_r = 0; j_p = 0; b = 0; ill = 0;
        r = 2'b00; op = 4'd0; t = 3'd0; imm = 3'd0; cls = 0;
        if (o == 7'd3 && f == 3'd2) begin
            w = 1; a = 1; r = 2'b01;
        end else if (o == 7'd35 && f == 3'd2) begin
            m = 1; a = 1; imm = 3'b001;
        end else if (o == 7'd99 && f != 3'd2 && f != 3'd3) begin
            b = 1; imm = 3'b010; op = 4'd1; t = f;
        end else if (o == 7'd51 && s == 7'd0) begin
            w = 1; op = 4'(R_ALU[f]);
        end else if (o == 7'd51 && s == 7'd32 && (f == 3'd0 || f == 3'd5)) begin
            w = 1; op = (f == 3'd0) ? 4'd1 : 4'd9;
        end else if (o == 7'd51 && s == 7'd1 && mext == 1 && M_ALU[f] >= 0) begin
            w = 1; op = 4'(M_ALU[f]); cls = (f < 3'd2) ? 1 : 2;
        end else if (o == 7'd19 && ((f != 3'd1 && f != 3'd5) || s == 7'd0)) begin
            w = 1; a = 1; op = 4'(R_ALU[f]);
        end else if (o == 7'd19 && f == 3'd5 && s == 7'd32) begin
            w = 1; a = 1; op = 4'd9;
        end else if (o == 7'd111) begin
            w = 1; imm = 3'b011; j_p = 1; r = 2'b10;
        end else if (o == 7'd55) begin
            w = 1; imm = 3'b100; r = 2'b11;
        end else if (o == 7'd103 && f == 3'd0) begin
            w = 1; a = 1; j_r = 1; r = 2'b10;
        end else begin
            ill = 1;
        end
        ctl = {w, m, a, j_r, j_p, b, r, op, t, ill};
    endfunction

    // Drive one cycle of inputs, check the combinational immediate format, then advance the model.
    task automatic step(input logic r, input logic [6:0] o, input logic [2:0] f,
                        input logic [6:0] s, input logic fl, input logic st);
        logic [15:0] ctl;
        logic [2:0]  imm;
        int          cls;
        @(negedge clk);
        rst = r; opc = o; f3 = f; f7 = s; flush_e = fl; stall_e = st;
        #1;
        for (int d = 0; d < 3; d++) begin
            ref_dec(o, f, s, P_MEXT[d], ctl, imm, cls);
            checks++;
            if (imm_src[d] !== imm) begin
                errors++;
                $display("FAIL imm_src dut%0d opc=%0d f3=%0d f7=%0d actual=%b required=%b",
                         d, o, f, s, imm_src[d], imm);
            end
        end
        @(posedge clk);
        for (int d = 0; d < 3; d++) begin
            ref_dec(o, f, s, P_MEXT[d], ctl, imm, cls);
            if (r || fl) begin
                m_e[d] = '0;
                m_left[d] = 0;
            end else if (st || m_left[d] > 0) begin
                if (m_left[d] > 0 && !st) m_left[d]--;
            end else begin
                m_e[d] = ctl;
                m_left[d] = (cls == 1) ? P_MUL[d] - 1 : (cls == 2) ? P_DIV[d] - 1 : 0;
            end
            exp_q[d].push_back({m_e[d], m_left[d] != 0});
        end
    endtask

    task automatic addi(input int n);
        for (int i = 0; i < n; i++) step(0, 7'd19, 3'd0, 7'd0, 0, 0);
    endtask

    // Monitor: after every edge compare each instance's E-stage outputs with the queued expectation.
    always @(negedge clk) begin
        logic [16:0] e;
        for (int d = 0; d < 3; d++) begin
            if (exp_q[d].size() != 0) begin
                e = exp_q[d].pop_front();
                checks++;
                if (act_v[d] !== e) begin
                    errors++;
                    $display("FAIL e_stage dut%0d actual=%b required=%b", d, act_v[d], e);
                end
            end
        end
    end

    initial begin
        int k;
        logic [6:0] o, s;
        rst = 1; opc = 0; f3 = 0; f7 = 0; flush_e = 0; stall_e = 0;
        for (int d = 0; d < 3; d++) begin
            m_e[d] = '0;
            m_left[d] = 0;
        end
        // reset state
        step(1, 7'd0, 3'd0, 7'd0, 0, 0);
        step(1, 7'd0, 3'd0, 7'd0, 0, 0);
        // sub
        step(0, 7'd51, 3'd0, 7'd32, 0, 0);
        addi(1);
        // mul: busy then release
        step(0, 7'd51, 3'd0, 7'd1, 0, 0);
        addi(4);
        // div flushed in its fourth busy cycle
        step(0, 7'd51, 3'd4, 7'd1, 0, 0);
        addi(3);
        step(0, 7'd19, 3'd0, 7'd0, 1, 0);
        addi(2);
        // mul stalled for two busy cycles
        step(0, 7'd51, 3'd1, 7'd1, 0, 0);
        step(0, 7'd19, 3'd0, 7'd0, 0, 1);
        step(0, 7'd19, 3'd0, 7'd0, 0, 1);
        addi(4);
        // reset in the middle of a div, then a normal addi
        step(0, 7'd51, 3'd7, 7'd1, 0, 0);
        addi(3);
        step(1, 7'd19, 3'd0, 7'd0, 0, 0);
        addi(2);
        // illegal opcode and each legal class once
        step(0, 7'd23, 3'd0, 7'd0, 0, 0);
        step(0, 7'd3, 3'd2, 7'd0, 0, 0);
        step(0, 7'd35, 3'd2, 7'd0, 0, 0);
        step(0, 7'd99, 3'd5, 7'd0, 0, 0);
        step(0, 7'd111, 3'd3, 7'd5, 0, 0);
        step(0, 7'd55, 3'd1, 7'd9, 0, 0);
        step(0, 7'd103, 3'd0, 7'd0, 0, 0);
        step(0, 7'd19, 3'd5, 7'd32, 0, 0);
        step(0, 7'd51, 3'd2, 7'd1, 0, 0);
        addi(10);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            k = $urandom_range(0, 9);
            o = (k == 9) ? 7'($urandom_range(0, 127)) : 7'(OPS[k]);
            case ($urandom_range(0, 3))
                0:       s = 7'd0;
                1:       s = 7'd32;
                2:       s = 7'd1;
                default: s = 7'($urandom_range(0, 127));
            endcase
            step(($urandom_range(0, 63) == 0), o, 3'($urandom_range(0, 7)), s,
                 ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
        end
        addi(10);
        @(negedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (exp_q[d].size() != 0) begin
                errors++;
                $display("FAIL drain dut%0d actual=%0d required=0", d, exp_q[d].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
